// File: rtl/fl_dp_alloc_ctrl.sv
// Dispatch-side allocation controller: grants dispatch lanes in order against
// the freelist available count, and blocks allocation during the recovery
// window that follows a rollback.
module fl_dp_alloc_ctrl #(
   parameter int C_DP_NUM      = 2,
   parameter int C_ARCH_IDX_W  = 5,
   parameter int C_RECOVER_CYC = 2,
   parameter int C_CNT_W       = 16
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic                                    rollback_i,
   input  logic [C_DP_NUM-1:0]                     dp_req_i,
   input  logic [C_DP_NUM-1:0][C_ARCH_IDX_W-1:0]   dp_rd_i,
   input  logic [1:0]                              fl_avail_i,
   output logic [C_DP_NUM-1:0]                     dp_gnt_o,
   output logic [C_DP_NUM-1:0]                     fl_dp_num_o,
   output logic [C_DP_NUM-1:0][C_ARCH_IDX_W-1:0]   fl_rd_idx_o,
   output logic                                    stall_o,
   output logic                                    recover_busy_o,
   output logic                                    avail_err_o,
   output logic [C_CNT_W-1:0]                      alloc_cnt_o
);

   typedef enum logic {
      IDLE_OK = 1'b0,
      RECOVER = 1'b1
   } state_t;

   localparam logic [3:0] RECOVER_LD = 4'(C_RECOVER_CYC);

   state_t               state_q, state_d;
   logic [3:0]           rcnt_q, rcnt_d;
   logic [C_CNT_W-1:0]   alloc_cnt_q;
   logic                 avail_err_q;

   logic [1:0]           need;
   logic [1:0]           avail;
   logic [1:0]           need_sum;
   logic [1:0]           gnt;
   logic                 block;

   // State register and recovery counter; a rollback seen during reset is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE_OK;
         rcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Next-state logic: rollback (re)loads the window, RECOVER counts down to 1 then exits.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (rollback_i) begin
         rcnt_d  = RECOVER_LD;
         state_d = (C_RECOVER_CYC == 0) ? IDLE_OK : RECOVER;
      end else if (state_q == RECOVER) begin
         rcnt_d = rcnt_q - 4'd1;
         if (rcnt_q == 4'd1) begin
            state_d = IDLE_OK;
         end
      end
   end

   // Lane needs, available-count decode and the in-order grant decision.
   always_comb begin
      need[0]  = dp_req_i[0] & (dp_rd_i[0] != '0);
      need[1]  = dp_req_i[1] & (dp_rd_i[1] != '0);
      case (fl_avail_i)
         2'b01:   avail = 2'd1;
         2'b11:   avail = 2'd2;
         default: avail = 2'd0;
      endcase
      need_sum = {1'b0, need[0]} + {1'b0, need[1]};
      block    = rst_i | rollback_i | (state_q == RECOVER);
      gnt      = 2'b00;
      if (!block) begin
         gnt[0] = dp_req_i[0] & (!need[0] | (avail >= 2'd1));
         gnt[1] = dp_req_i[1] & (gnt[0] | !dp_req_i[0]) & (need_sum <= avail);
      end
   end

   // Output drive; everything combinational is held at zero while in reset.
   always_comb begin
      dp_gnt_o       = gnt;
      fl_dp_num_o    = gnt & need;
      fl_rd_idx_o[0] = gnt[0] ? dp_rd_i[0] : '0;
      fl_rd_idx_o[1] = gnt[1] ? dp_rd_i[1] : '0;
      stall_o        = 1'b0;
      recover_busy_o = 1'b0;
      if (!rst_i) begin
         stall_o        = |(dp_req_i & ~gnt);
         recover_busy_o = (state_q == RECOVER) | rollback_i;
      end
   end

   // Sticky illegal-encoding flag and wrapping allocation counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         avail_err_q <= 1'b0;
         alloc_cnt_q <= '0;
      end else begin
         if (fl_avail_i == 2'b10) begin
            avail_err_q <= 1'b1;
         end
         alloc_cnt_q <= alloc_cnt_q + C_CNT_W'(fl_dp_num_o[0]) + C_CNT_W'(fl_dp_num_o[1]);
      end
   end

   assign avail_err_o = avail_err_q;
   assign alloc_cnt_o = alloc_cnt_q;

endmodule

// File: tb/tb_fl_dp_alloc_ctrl.sv
// Scoreboard bench for fl_dp_alloc_ctrl: directed vectors push their expected
// outputs into a queue, and a monitor pops and compares on the falling edge.
module tb_fl_dp_alloc_ctrl;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             rollback_i;
   logic [1:0]       dp_req_i;
   logic [1:0][4:0]  dp_rd_i;
   logic [1:0]       fl_avail_i;
   logic [1:0]       dp_gnt_o;
   logic [1:0]       fl_dp_num_o;
   logic [1:0][4:0]  fl_rd_idx_o;
   logic             stall_o;
   logic             recover_busy_o;
   logic             avail_err_o;
   logic [15:0]      alloc_cnt_o;

   typedef struct {
      int          id;
      logic [1:0]  gnt;
      logic [1:0]  num;
      logic [9:0]  idx;
      logic        stall;
      logic        busy;
      logic        err;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   vec_id = 0;

   fl_dp_alloc_ctrl #(
      .C_DP_NUM      (2),
      .C_ARCH_IDX_W  (5),
      .C_RECOVER_CYC (2),
      .C_CNT_W       (16)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rollback_i     (rollback_i),
      .dp_req_i       (dp_req_i),
      .dp_rd_i        (dp_rd_i),
      .fl_avail_i     (fl_avail_i),
      .dp_gnt_o       (dp_gnt_o),
      .fl_dp_num_o    (fl_dp_num_o),
      .fl_rd_idx_o    (fl_rd_idx_o),
      .stall_o        (stall_o),
      .recover_busy_o (recover_busy_o),
      .avail_err_o    (avail_err_o),
      .alloc_cnt_o    (alloc_cnt_o)
   );

   // Free-running clock, 10 ns period.
   always #5 clk_i = ~clk_i;

   // Compare one output field and record the result.
   task automatic checkOutput(input int id, input string field,
                              input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL vec%0d %s: got=%0h want=%0h", id, field, act, exp);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and queue its expectation.
   task automatic applyStimulus(input logic rst, input logic rb, input logic [1:0] req,
                                input logic [4:0] rd1, input logic [4:0] rd0,
                                input logic [1:0] av, input logic [1:0] e_gnt,
                                input logic [1:0] e_num, input logic [4:0] e_idx1,
                                input logic [4:0] e_idx0, input logic e_stall,
                                input logic e_busy, input logic e_err,
                                input logic [15:0] e_cnt);
      exp_t e;
      @(posedge clk_i);
      #1;
      rst_i      = rst;
      rollback_i = rb;
      dp_req_i   = req;
      dp_rd_i[1] = rd1;
      dp_rd_i[0] = rd0;
      fl_avail_i = av;
      e.id    = vec_id;
      e.gnt   = e_gnt;
      e.num   = e_num;
      e.idx   = {e_idx1, e_idx0};
      e.stall = e_stall;
      e.busy  = e_busy;
      e.err   = e_err;
      e.cnt   = e_cnt;
      sb.push_back(e);
      vec_id++;
   endtask

   // Monitor: whenever an expectation is pending, compare against the live outputs.
   always @(negedge clk_i) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput(e.id, "gnt",   16'(dp_gnt_o),       16'(e.gnt));
         checkOutput(e.id, "dpnum", 16'(fl_dp_num_o),    16'(e.num));
         checkOutput(e.id, "rdidx", 16'(fl_rd_idx_o),    16'(e.idx));
         checkOutput(e.id, "stall", 16'(stall_o),        16'(e.stall));
         checkOutput(e.id, "busy",  16'(recover_busy_o), 16'(e.busy));
         checkOutput(e.id, "err",   16'(avail_err_o),    16'(e.err));
         checkOutput(e.id, "cnt",   alloc_cnt_o,         e.cnt);
      end
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      rst_i      = 1'b1;
      rollback_i = 1'b0;
      dp_req_i   = 2'b00;
      dp_rd_i    = '0;
      fl_avail_i = 2'b00;

      $display("[TB] reset phase");
      //            rst  rb   req    rd1 rd0 av     gnt    num    i1 i0 stl  bsy  err  cnt
      applyStimulus(1'b1,1'b1,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b0,16'd0);
      applyStimulus(1'b1,1'b0,2'b11, 5,  3, 2'b10, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b0,16'd0);

      $display("[TB] grant rules");
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b11, 2'b11, 5, 3, 1'b0,1'b0,1'b0,16'd0);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b01, 2'b01, 2'b01, 0, 3, 1'b1,1'b0,1'b0,16'd2);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1,1'b0,1'b0,16'd3);
      applyStimulus(1'b0,1'b0,2'b11, 7,  0, 2'b01, 2'b11, 2'b10, 7, 0, 1'b0,1'b0,1'b0,16'd3);
      applyStimulus(1'b0,1'b0,2'b11, 0,  4, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1,1'b0,1'b0,16'd4);
      applyStimulus(1'b0,1'b0,2'b10, 6,  0, 2'b00, 2'b00, 2'b00, 0, 0, 1'b1,1'b0,1'b0,16'd4);
      applyStimulus(1'b0,1'b0,2'b10, 6,  0, 2'b01, 2'b10, 2'b10, 6, 0, 1'b0,1'b0,1'b0,16'd4);
      applyStimulus(1'b0,1'b0,2'b00, 6,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b0,16'd5);
      applyStimulus(1'b0,1'b0,2'b01, 6,  0, 2'b00, 2'b01, 2'b00, 0, 0, 1'b0,1'b0,1'b0,16'd5);

      $display("[TB] single rollback");
      applyStimulus(1'b0,1'b1,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd5);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd5);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd5);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b11, 2'b11, 5, 3, 1'b0,1'b0,1'b0,16'd5);

      $display("[TB] back-to-back rollback");
      applyStimulus(1'b0,1'b1,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd7);
      applyStimulus(1'b0,1'b1,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd7);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd7);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b0,16'd7);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b11, 2'b11, 5, 3, 1'b0,1'b0,1'b0,16'd7);

      $display("[TB] illegal avail code");
      applyStimulus(1'b0,1'b0,2'b01, 0,  9, 2'b10, 2'b00, 2'b00, 0, 0, 1'b1,1'b0,1'b0,16'd9);
      applyStimulus(1'b0,1'b0,2'b00, 0,  9, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b1,16'd9);
      applyStimulus(1'b0,1'b0,2'b01, 0,  9, 2'b11, 2'b01, 2'b01, 0, 9, 1'b0,1'b0,1'b1,16'd9);

      $display("[TB] reset during recovery");
      applyStimulus(1'b0,1'b1,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b1,1'b1,1'b1,16'd10);
      applyStimulus(1'b1,1'b0,2'b11, 5,  3, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b1,16'd10);
      applyStimulus(1'b0,1'b0,2'b11, 5,  3, 2'b11, 2'b11, 2'b11, 5, 3, 1'b0,1'b0,1'b0,16'd0);

      $display("[TB] counter wrap");
      for (int i = 0; i < 65533; i++) begin
         @(posedge clk_i);
         #1;
         rollback_i = 1'b0;
         dp_req_i   = 2'b01;
         dp_rd_i[1] = 5'd0;
         dp_rd_i[0] = 5'd9;
         fl_avail_i = 2'b11;
      end
      applyStimulus(1'b0,1'b0,2'b01, 0,  9, 2'b11, 2'b01, 2'b01, 0, 9, 1'b0,1'b0,1'b0,16'd65535);
      applyStimulus(1'b0,1'b0,2'b00, 0,  9, 2'b11, 2'b00, 2'b00, 0, 0, 1'b0,1'b0,1'b0,16'd0);

      repeat (3) @(posedge clk_i);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got=%0d pending want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
